// File: rtl/bus_datapath_gen2_if.sv
// ALU and memory request/acknowledge handshake bundle of the single-bus datapath.
// The datapath uses the master side; the ALU/memory models use the slave side.
interface bus_datapath_gen2_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [5:0]          alu_op_q;
  logic                alu_req;
  logic [2*DATA_W-1:0] alu_result;
  logic                alu_done;

  logic [DATA_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_req;
  logic                mem_we;
  logic                mem_ack;

  modport master (
    output alu_a, alu_b, alu_op_q, alu_req,
    input  alu_result, alu_done,
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  alu_a, alu_b, alu_op_q, alu_req,
    output alu_result, alu_done,
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/bus_datapath_gen2.sv
// Single-bus CPU datapath: register file, PC/IR/MAR/MDR/Y/Z/HI/LO, one-hot bus mux,
// plus independent ALU and memory handshake FSMs with memory timeout.
//
// state  | meaning
// A_IDLE | ALU free; alu_start captures Y, bus and opcode
// A_WAIT | alu_req high; alu_done writes the result into Z
// M_IDLE | memory free; mem_read/mem_write captures MAR (and MDR on write)
// M_REQ  | mem_req high; ends on mem_ack or after MEM_TIMEOUT cycles
module bus_datapath_gen2 #(
  parameter int DATA_W      = 32,
  parameter int RF_DEPTH    = 16,
  parameter int SEL_W       = 4,
  parameter int R0_ZERO     = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              i_clock,
  input  logic              i_clear,
  input  logic [10:0]       i_bus_src,
  input  logic [8:0]        i_bus_load,
  input  logic [SEL_W-1:0]  i_rf_sel,
  input  logic [DATA_W-1:0] i_tb_data,
  input  logic              i_pc_inc,
  input  logic              i_alu_start,
  input  logic [5:0]        i_alu_op,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  output logic              o_alu_busy,
  output logic              o_mem_busy,
  output logic              o_mem_err,
  output logic [DATA_W-1:0] o_bus_value,
  output logic              o_bus_conflict,
  output logic [DATA_W-1:0] o_ir_value,
  bus_datapath_gen2_if.master hs
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {A_IDLE, A_WAIT} alu_state_t;
  typedef enum logic {M_IDLE, M_REQ}  mem_state_t;

  logic [DATA_W-1:0]   r_rf [RF_DEPTH];
  logic [DATA_W-1:0]   r_pc, r_ir, r_y, r_mar, r_hi, r_lo, r_mdr;
  logic [2*DATA_W-1:0] r_z;
  logic                r_bus_conflict;

  alu_state_t          r_alu_state;
  logic [DATA_W-1:0]   r_alu_a, r_alu_b;
  logic [5:0]          r_alu_op;
  logic                r_alu_req;

  mem_state_t          r_mem_state;
  logic [DATA_W-1:0]   r_mem_addr, r_mem_wdata;
  logic                r_mem_req, r_mem_we, r_mem_err;
  logic [CNT_W-1:0]    r_mem_cnt;

  logic [DATA_W-1:0]   w_src_val [11];
  logic [DATA_W-1:0]   w_bus;
  logic [DATA_W-1:0]   w_rf_rd;
  logic [8:0]          w_load;
  logic                w_onehot, w_conflict;
  logic                w_sel_ok, w_sel_zero, w_rf_wr_ok;
  logic [CNT_W-1:0]    w_cnt_nxt;

  // RF index decode: out-of-range and (optionally) index 0 read as zero and are never written
  always_comb begin
    w_sel_ok   = (int'(i_rf_sel) < RF_DEPTH);
    w_sel_zero = (R0_ZERO != 0) && (i_rf_sel == '0);
    w_rf_wr_ok = w_sel_ok && !w_sel_zero;
    w_rf_rd    = '0;
    if (w_rf_wr_ok) w_rf_rd = r_rf[i_rf_sel];
  end

  always_comb begin
    w_src_val[0]  = i_tb_data;
    w_src_val[1]  = w_rf_rd;
    w_src_val[2]  = r_pc;
    w_src_val[3]  = r_ir;
    w_src_val[4]  = r_y;
    w_src_val[5]  = r_z[DATA_W-1:0];
    w_src_val[6]  = r_z[2*DATA_W-1:DATA_W];
    w_src_val[7]  = r_mar;
    w_src_val[8]  = r_hi;
    w_src_val[9]  = r_lo;
    w_src_val[10] = r_mdr;
  end

  // A multi-driver cycle yields a zero bus and blocks every load
  always_comb begin
    w_onehot   = (i_bus_src != '0) && ((i_bus_src & (i_bus_src - 11'd1)) == '0);
    w_conflict = (i_bus_src != '0) && !w_onehot;
    w_load     = w_conflict ? '0 : i_bus_load;
    w_bus      = '0;
    if (w_onehot) begin
      for (int i = 0; i < 11; i++) begin
        if (i_bus_src[i]) w_bus = w_bus | w_src_val[i];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
      r_pc           <= '0;
      r_ir           <= '0;
      r_y            <= '0;
      r_mar          <= '0;
      r_hi           <= '0;
      r_lo           <= '0;
      r_bus_conflict <= 1'b0;
    end else begin
      if (w_load[0] && w_rf_wr_ok) r_rf[i_rf_sel] <= w_bus;
      if (w_load[1])     r_pc <= w_bus;
      else if (i_pc_inc) r_pc <= r_pc + DATA_W'(1);
      if (w_load[2]) r_ir  <= w_bus;
      if (w_load[3]) r_y   <= w_bus;
      if (w_load[4]) r_mar <= w_bus;
      if (w_load[5]) r_hi  <= w_bus;
      if (w_load[6]) r_lo  <= w_bus;
      if (w_conflict) r_bus_conflict <= 1'b1;
    end
  end

  // Z lives with the ALU FSM so a completing operation outranks a bus load into Z
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_alu_state <= A_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_req   <= 1'b0;
      r_z         <= '0;
    end else begin
      case (r_alu_state)
        A_IDLE: begin
          if (w_load[8]) r_z <= {{DATA_W{1'b0}}, w_bus};
          if (i_alu_start) begin
            r_alu_a     <= r_y;
            r_alu_b     <= w_bus;
            r_alu_op    <= i_alu_op;
            r_alu_req   <= 1'b1;
            r_alu_state <= A_WAIT;
          end
        end
        A_WAIT: begin
          if (hs.alu_done) begin
            r_z         <= hs.alu_result;
            r_alu_req   <= 1'b0;
            r_alu_state <= A_IDLE;
          end else if (w_load[8]) begin
            r_z <= {{DATA_W{1'b0}}, w_bus};
          end
        end
        default: begin
          r_alu_req   <= 1'b0;
          r_alu_state <= A_IDLE;
        end
      endcase
    end
  end

  assign w_cnt_nxt = r_mem_cnt + CNT_W'(1);

  // MDR lives with the memory FSM; bus loads into it only land while the FSM is idle
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_mem_state <= M_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_err   <= 1'b0;
      r_mem_cnt   <= '0;
      r_mdr       <= '0;
    end else begin
      case (r_mem_state)
        M_IDLE: begin
          if (w_load[7]) r_mdr <= w_bus;
          if (i_mem_read || i_mem_write) begin
            r_mem_addr  <= r_mar;
            r_mem_we    <= !i_mem_read;
            if (!i_mem_read) r_mem_wdata <= r_mdr;
            r_mem_req   <= 1'b1;
            r_mem_cnt   <= '0;
            r_mem_state <= M_REQ;
          end
        end
        M_REQ: begin
          if (hs.mem_ack) begin
            if (!r_mem_we) r_mdr <= hs.mem_rdata;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_cnt   <= '0;
            r_mem_state <= M_IDLE;
          end else if (w_cnt_nxt == CNT_W'(MEM_TIMEOUT)) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_cnt   <= '0;
            r_mem_err   <= 1'b1;
            r_mem_state <= M_IDLE;
          end else begin
            r_mem_cnt <= w_cnt_nxt;
          end
        end
        default: begin
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
          r_mem_state <= M_IDLE;
        end
      endcase
    end
  end

  assign hs.alu_a     = r_alu_a;
  assign hs.alu_b     = r_alu_b;
  assign hs.alu_op_q  = r_alu_op;
  assign hs.alu_req   = r_alu_req;
  assign hs.mem_addr  = r_mem_addr;
  assign hs.mem_wdata = r_mem_wdata;
  assign hs.mem_req   = r_mem_req;
  assign hs.mem_we    = r_mem_we;

  assign o_alu_busy     = (r_alu_state != A_IDLE);
  assign o_mem_busy     = (r_mem_state != M_IDLE);
  assign o_mem_err      = r_mem_err;
  assign o_bus_value    = w_bus;
  assign o_bus_conflict = r_bus_conflict;
  assign o_ir_value     = r_ir;

endmodule

// File: tb/tb_bus_datapath_gen2.sv
// Bench for bus_datapath_gen2: transfer table, handshake sequences, and random bus
// traffic checked against a register-level model.
module tb_bus_datapath_gen2;
  localparam int S_TB = 0, S_RF = 1, S_PC = 2, S_IR = 3, S_Y = 4, S_ZLO = 5, S_ZHI = 6;
  localparam int S_MAR = 7, S_HI = 8, S_LO = 9, S_MDR = 10;
  localparam int L_RF = 0, L_PC = 1, L_IR = 2, L_Y = 3, L_MAR = 4, L_HI = 5, L_LO = 6;
  localparam int L_MDR = 7, L_Z = 8;

  logic        clk = 1'b0;
  logic        clear;
  logic [10:0] bus_src;
  logic [8:0]  bus_load;
  logic [3:0]  rf_sel;
  logic [31:0] tb_data;
  logic        pc_inc, alu_start, mem_read, mem_write;
  logic [5:0]  alu_op;
  logic        alu_busy, mem_busy, mem_err, bus_conflict;
  logic [31:0] bus_value, ir_value;

  int pass_cnt = 0;
  int total_cnt = 0;

  bus_datapath_gen2_if #(.DATA_W(32)) bus_if ();

  bus_datapath_gen2 dut (
    .i_clock        (clk),
    .i_clear        (clear),
    .i_bus_src      (bus_src),
    .i_bus_load     (bus_load),
    .i_rf_sel       (rf_sel),
    .i_tb_data      (tb_data),
    .i_pc_inc       (pc_inc),
    .i_alu_start    (alu_start),
    .i_alu_op       (alu_op),
    .i_mem_read     (mem_read),
    .i_mem_write    (mem_write),
    .o_alu_busy     (alu_busy),
    .o_mem_busy     (mem_busy),
    .o_mem_err      (mem_err),
    .o_bus_value    (bus_value),
    .o_bus_conflict (bus_conflict),
    .o_ir_value     (ir_value),
    .hs             (bus_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [10:0] src;
    logic [8:0]  load;
    logic [31:0] data;
    logic [3:0]  sel;
    int          rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [15];

  // Register-level model for the random phase
  logic [31:0] m_rf [16];
  logic [31:0] m_pc, m_ir, m_y, m_mar, m_hi, m_lo, m_mdr;
  logic [63:0] m_z;
  logic        m_conf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic idle();
    bus_src = '0; bus_load = '0; pc_inc = 1'b0;
    alu_start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    bus_if.alu_done = 1'b0; bus_if.mem_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wr(input int dst, input logic [31:0] v, input logic [3:0] sel);
    bus_src = 11'd1; tb_data = v; bus_load = 9'd1 << dst; rf_sel = sel;
    tick();
    idle();
  endtask

  task automatic rd(input int src, input logic [3:0] sel, output logic [31:0] v);
    bus_src = 11'd1 << src; bus_load = '0; rf_sel = sel;
    #1;
    v = bus_value;
    bus_src = '0;
  endtask

  function automatic logic [31:0] srcval(input int k, input logic [3:0] s, input logic [31:0] d);
    case (k)
      0:  return d;
      1:  return (s == 4'd0) ? 32'd0 : m_rf[s];
      2:  return m_pc;
      3:  return m_ir;
      4:  return m_y;
      5:  return m_z[31:0];
      6:  return m_z[63:32];
      7:  return m_mar;
      8:  return m_hi;
      9:  return m_lo;
      default: return m_mdr;
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    int          reqcnt, wecnt, tocnt;
    bit          done_seen;

    clear = 1'b1; rf_sel = '0; tb_data = '0; alu_op = '0;
    bus_if.alu_result = '0; bus_if.mem_rdata = '0;
    idle();
    tick(); tick();
    clear = 1'b0;

    chk("rst_conflict", bus_conflict, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_alu_req", bus_if.alu_req, 0);
    chk("rst_mem_req", bus_if.mem_req, 0);
    rd(S_PC, 0, v); chk("rst_pc", v, 0);

    // ---- table-driven transfers (rows build on each other) ----
    vt[0]  = '{11'h001, 9'h008, 32'hA5A5A5A5, 4'd0, S_Y,   32'hA5A5A5A5};
    vt[1]  = '{11'h001, 9'h001, 32'h00000012, 4'd0, S_RF,  32'h00000000};
    vt[2]  = '{11'h001, 9'h001, 32'h00000034, 4'd5, S_RF,  32'h00000034};
    vt[3]  = '{11'h001, 9'h002, 32'h00001234, 4'd0, S_PC,  32'h00001234};
    vt[4]  = '{11'h001, 9'h004, 32'hCAFEF00D, 4'd0, S_IR,  32'hCAFEF00D};
    vt[5]  = '{11'h001, 9'h010, 32'h00000100, 4'd0, S_MAR, 32'h00000100};
    vt[6]  = '{11'h001, 9'h020, 32'h00000011, 4'd0, S_HI,  32'h00000011};
    vt[7]  = '{11'h001, 9'h040, 32'h00000022, 4'd0, S_LO,  32'h00000022};
    vt[8]  = '{11'h001, 9'h080, 32'h00000055, 4'd0, S_MDR, 32'h00000055};
    vt[9]  = '{11'h001, 9'h100, 32'hFFFF0001, 4'd0, S_ZLO, 32'hFFFF0001};
    vt[10] = '{11'h002, 9'h008, 32'h00000000, 4'd5, S_Y,   32'h00000034};
    vt[11] = '{11'h000, 9'h008, 32'h00009999, 4'd0, S_Y,   32'h00000000};
    vt[12] = '{11'h005, 9'h080, 32'h00000999, 4'd0, S_MDR, 32'h00000055};
    vt[13] = '{11'h008, 9'h020, 32'h00000000, 4'd0, S_HI,  32'hCAFEF00D};
    vt[14] = '{11'h001, 9'h050, 32'h00000077, 4'd0, S_MAR, 32'h00000077};
    for (int i = 0; i < 15; i++) begin
      bus_src = vt[i].src; bus_load = vt[i].load; tb_data = vt[i].data; rf_sel = vt[i].sel;
      tick();
      idle();
      rd(vt[i].rd, vt[i].sel, v);
      chk($sformatf("vec%0d", i), v, vt[i].exp);
    end
    chk("ir_value", ir_value, 32'hCAFEF00D);
    chk("conflict_sticky", bus_conflict, 1);

    bus_src = 11'h005; tb_data = 32'h1;
    #1 chk("conflict_bus_zero", bus_value, 0);
    idle();
    do_clear();
    chk("conflict_cleared", bus_conflict, 0);

    // ---- PC wrap and load priority ----
    wr(L_PC, 32'hFFFFFFFF, 0);
    pc_inc = 1'b1; tick(); idle();
    rd(S_PC, 0, v); chk("pc_wrap", v, 0);
    bus_src = 11'd1; tb_data = 32'd7; bus_load = 9'd1 << L_PC; pc_inc = 1'b1;
    tick(); idle();
    rd(S_PC, 0, v); chk("pc_load_wins", v, 7);

    // ---- ALU handshake ----
    wr(L_Y, 32'd6, 0);
    bus_src = 11'd1; tb_data = 32'd7; alu_start = 1'b1; alu_op = 6'h2A;
    tick(); idle();
    chk("alu_a", bus_if.alu_a, 6);
    chk("alu_b", bus_if.alu_b, 7);
    chk("alu_op_q", bus_if.alu_op_q, 6'h2A);
    chk("alu_busy_on", alu_busy, 1);
    reqcnt = 0; done_seen = 0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (bus_if.alu_req) reqcnt++;
      if (c == 1) begin
        alu_start = 1'b1; alu_op = 6'h3F; bus_src = 11'd1; tb_data = 32'd99;
      end
      if (reqcnt == 3) begin
        bus_if.alu_done = 1'b1; bus_if.alu_result = {32'h1, 32'd42};
        bus_src = 11'd1; tb_data = 32'd77; bus_load = 9'd1 << L_Z;
        done_seen = 1;
      end
      tick(); idle();
    end
    chk("alu_done_reached", done_seen, 1);
    chk("alu_req_cycles", reqcnt, 3);
    chk("alu_req_low", bus_if.alu_req, 0);
    chk("alu_busy_off", alu_busy, 0);
    chk("alu_op_kept", bus_if.alu_op_q, 6'h2A);
    chk("alu_b_kept", bus_if.alu_b, 7);
    rd(S_ZLO, 0, v); chk("z_lo_result", v, 42);
    rd(S_ZHI, 0, v); chk("z_hi_result", v, 1);
    bus_if.alu_done = 1'b1; bus_if.alu_result = 64'h5;
    tick(); idle();
    rd(S_ZLO, 0, v); chk("alu_done_idle_ignored", v, 42);
    wr(L_Z, 32'd5, 0);
    rd(S_ZHI, 0, v); chk("z_load_hi_clear", v, 0);
    rd(S_ZLO, 0, v); chk("z_load_lo", v, 5);

    // ---- memory read with 2 wait cycles ----
    wr(L_MAR, 32'h100, 0);
    wr(L_MDR, 32'h11, 0);
    mem_read = 1'b1; tick(); idle();
    chk("mrd_req", bus_if.mem_req, 1);
    chk("mrd_addr", bus_if.mem_addr, 32'h100);
    chk("mrd_we", bus_if.mem_we, 0);
    chk("mrd_busy", mem_busy, 1);
    reqcnt = 0; done_seen = 0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (bus_if.mem_req) reqcnt++;
      if (c == 0) begin
        bus_src = 11'd1; tb_data = 32'h777; bus_load = (9'd1 << L_MAR) | (9'd1 << L_MDR);
      end
      if (c == 1) begin
        bus_src = 11'd1 << S_MDR;
        #1 chk("mdr_load_blocked", bus_value, 32'h11);
        chk("mem_addr_held", bus_if.mem_addr, 32'h100);
      end
      if (reqcnt == 3) begin
        bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hDEADBEEF; done_seen = 1;
      end
      tick(); idle();
    end
    chk("mrd_req_cycles", reqcnt, 3);
    chk("mrd_req_low", bus_if.mem_req, 0);
    chk("mrd_busy_off", mem_busy, 0);
    rd(S_MDR, 0, v); chk("mrd_mdr", v, 32'hDEADBEEF);
    rd(S_MAR, 0, v); chk("mar_loaded", v, 32'h777);
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h1;
    tick(); idle();
    rd(S_MDR, 0, v); chk("ack_idle_ignored", v, 32'hDEADBEEF);

    // ---- timeout ----
    mem_read = 1'b1; tick(); idle();
    tocnt = 0;
    for (int c = 0; c < 40 && bus_if.mem_req; c++) begin
      tocnt++;
      tick();
    end
    chk("timeout_cycles", tocnt, 15);
    chk("timeout_err", mem_err, 1);
    chk("timeout_busy", mem_busy, 0);
    rd(S_MDR, 0, v); chk("timeout_mdr", v, 32'hDEADBEEF);

    // ---- zero-wait write ----
    wr(L_MDR, 32'h55, 0);
    mem_write = 1'b1; tick(); idle();
    chk("mwr_we", bus_if.mem_we, 1);
    chk("mwr_wdata", bus_if.mem_wdata, 32'h55);
    wecnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus_if.mem_we) wecnt++;
      if (bus_if.mem_req) bus_if.mem_ack = 1'b1;
      tick(); idle();
    end
    chk("mwr_we_cycles", wecnt, 1);
    chk("mwr_req_low", bus_if.mem_req, 0);
    chk("mem_err_sticky", mem_err, 1);

    // ---- read and write together: read wins ----
    wr(L_MAR, 32'h200, 0);
    mem_read = 1'b1; mem_write = 1'b1; tick(); idle();
    chk("rw_we", bus_if.mem_we, 0);
    chk("rw_addr", bus_if.mem_addr, 32'h200);
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h0BADF00D;
    tick(); idle();
    rd(S_MDR, 0, v); chk("rw_mdr", v, 32'h0BADF00D);

    // ---- clear in the middle of both handshakes ----
    wr(L_RF, 32'h34, 4'd5);
    wr(L_Y, 32'd6, 0);
    mem_read = 1'b1; bus_src = 11'd1; tb_data = 32'd3; alu_start = 1'b1; alu_op = 6'h11;
    tick(); idle(); tick();
    chk("mid_alu_busy", alu_busy, 1);
    chk("mid_mem_busy", mem_busy, 1);
    do_clear();
    chk("clr_alu_req", bus_if.alu_req, 0);
    chk("clr_mem_req", bus_if.mem_req, 0);
    chk("clr_alu_busy", alu_busy, 0);
    chk("clr_mem_busy", mem_busy, 0);
    chk("clr_mem_err", mem_err, 0);
    chk("clr_alu_a", bus_if.alu_a, 0);
    chk("clr_alu_b", bus_if.alu_b, 0);
    chk("clr_alu_op", bus_if.alu_op_q, 0);
    chk("clr_mem_addr", bus_if.mem_addr, 0);
    chk("clr_mem_wdata", bus_if.mem_wdata, 0);
    for (int k = S_RF; k <= S_MDR; k++) begin
      rd(k, 4'd5, v); chk($sformatf("clr_src%0d", k), v, 0);
    end

    // ---- random bus traffic vs model ----
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_pc = '0; m_ir = '0; m_y = '0; m_mar = '0; m_hi = '0; m_lo = '0; m_mdr = '0;
    m_z = '0; m_conf = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int          r, cnt1, ksel;
      logic [31:0] exp;
      r = $urandom_range(0, 9);
      if (r == 0) bus_src = '0;
      else if (r == 1) begin
        int a, b;
        a = $urandom_range(0, 10);
        b = (a + $urandom_range(1, 10)) % 11;
        bus_src = (11'd1 << a) | (11'd1 << b);
      end else bus_src = 11'd1 << $urandom_range(0, 10);
      bus_load = 9'($urandom) & 9'($urandom);
      rf_sel   = 4'($urandom);
      tb_data  = $urandom;
      pc_inc   = 1'($urandom);
      cnt1 = $countones(bus_src);
      ksel = 0;
      for (int k = 0; k < 11; k++) if (bus_src[k]) ksel = k;
      exp = (cnt1 == 1) ? srcval(ksel, rf_sel, tb_data) : 32'd0;
      #1;
      chk("rnd_bus", bus_value, exp);
      chk("rnd_conflict", bus_conflict, m_conf);
      tick();
      if (cnt1 > 1) m_conf = 1'b1;
      if (cnt1 <= 1 && bus_load[L_PC]) m_pc = exp;
      else if (pc_inc) m_pc = m_pc + 32'd1;
      if (cnt1 <= 1) begin
        if (bus_load[L_RF] && rf_sel != 4'd0) m_rf[rf_sel] = exp;
        if (bus_load[L_IR])  m_ir  = exp;
        if (bus_load[L_Y])   m_y   = exp;
        if (bus_load[L_MAR]) m_mar = exp;
        if (bus_load[L_HI])  m_hi  = exp;
        if (bus_load[L_LO])  m_lo  = exp;
        if (bus_load[L_MDR]) m_mdr = exp;
        if (bus_load[L_Z])   m_z   = {32'd0, exp};
      end
      idle();
    end
    chk("rnd_ir_value", ir_value, m_ir);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bus_datapath_gen2.md
Name: bus_datapath_gen2

Overview:
Parametrised next-generation single-bus CPU datapath. It contains the register file, PC, IR, MAR, MDR, Y, a 2×DATA_W Z, HI and LO registers, and a one-hot bus multiplexer. It drives an external multi-cycle ALU and an external memory through request/acknowledge handshakes with timeout. It sits between the control unit, which supplies selects and loads, and the ALU and memory blocks.

Parameters:
DATA_W, 32, width of the bus and of every architectural register
RF_DEPTH, 16, number of register-file entries
SEL_W, 4, rf_sel width, equal to clog2(RF_DEPTH)
R0_ZERO, 1, when 1 register 0 always reads 0 and ignores writes
MEM_TIMEOUT, 15, number of cycles mem_req may stay high without mem_ack before abort

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
bus_src  in  11  one-hot bus driver select. Bit order: [0]TB [1]RF [2]PC [3]IR [4]Y [5]ZLO [6]ZHI [7]MAR [8]HI [9]LO [10]MDR
bus_load  in  9  register load enables from the bus. Bit order: [0]RF [1]PC [2]IR [3]Y [4]MAR [5]HI [6]LO [7]MDR [8]Z (bus value into Z low half; Z high half cleared)
rf_sel  in  SEL_W  register-file index used for RF read and RF write
tb_data  in  DATA_W  testbench/immediate value driven when bus_src[0] is set
pc_inc  in  1  increment PC by 1
alu_start  in  1  command pulse that launches an ALU operation
alu_op  in  6  ALU opcode, latched when alu_start is accepted
alu_a, alu_b  out  DATA_W  operand latches driven to the ALU
alu_op_q  out  6  latched opcode
alu_req  out  1  ALU request; held high until alu_done
alu_result  in  2*DATA_W  ALU result
alu_done  in  1  ALU completion
alu_busy  out  1  high while the ALU FSM is not in A_IDLE
mem_read, mem_write  in  1  memory command pulses
mem_addr, mem_wdata  out  DATA_W  memory address and write-data latches
mem_rdata  in  DATA_W  memory read data
mem_req, mem_we  out  1  memory request and write strobe
mem_ack  in  1  memory acknowledge
mem_busy  out  1  high while the memory FSM is not in M_IDLE
mem_err  out  1  sticky flag, set on memory timeout
bus_value  out  DATA_W  current bus value
bus_conflict  out  1  sticky flag, set on an illegal multi-driver cycle
ir_value  out  DATA_W  IR contents, for the control unit

Behaviour:
- Reset: the edge with clear=1 zeroes all registers, the RF, operand and address latches, mem_err, bus_conflict and the timeout counter. Both FSMs return to IDLE. alu_req and mem_req are low from the next cycle. clear overrides every other input, including mid-handshake.
- Bus (combinational):
  - Exactly one bus_src bit set: bus carries that source.
  - Zero bits set: bus is 0.
  - More than one bit set: bus is 0, every bus_load in that cycle is suppressed, and bus_conflict is set at the edge.
- RF:
  - Reads at rf_sel are asynchronous.
  - With R0_ZERO=1, index 0 reads 0 and writes to it are dropped.
  - rf_sel values at or above RF_DEPTH read 0 and are not written.
- PC:
  - Loads from the bus on bus_load[1].
  - Otherwise pc_inc adds 1, wrapping modulo 2^DATA_W.
  - If bus_load[1] and pc_inc are both set, the load wins.
- Loads: each enabled register takes the bus value at the rising edge. The new value is visible on the bus the next cycle.
- ALU FSM, states A_IDLE and A_WAIT:
  - In A_IDLE, alu_start latches alu_a=Y, alu_b=bus and alu_op_q=alu_op, then moves to A_WAIT.
  - In A_WAIT, alu_req=1. At the edge where alu_done=1, Z takes alu_result and the FSM returns to A_IDLE, so alu_req is low the next cycle.
  - alu_start while in A_WAIT is ignored.
  - alu_done while in A_IDLE is ignored.
  - ALU write-back to Z has priority over a bus_load[8] in the same edge.
- Memory FSM, states M_IDLE and M_REQ:
  - In M_IDLE, a command latches mem_addr=MAR and sets mem_we for a write. On a write, mem_wdata is latched from MDR. The FSM then moves to M_REQ.
  - If mem_read and mem_write arrive together, the read executes and the write is dropped.
  - In M_REQ, mem_req=1 and the timeout counter increments each cycle.
  - mem_ack=1 ends the request. On a read, MDR takes mem_rdata at that edge. The counter resets and the FSM returns to M_IDLE.
  - If the counter reaches MEM_TIMEOUT without an ack, the FSM returns to M_IDLE, mem_err is set, and MDR is unchanged.
  - A zero-wait memory (ack in the first M_REQ cycle) completes in 2 cycles from the command.
  - Commands while in M_REQ are ignored.
  - bus_load[7] (MDR) is ignored while mem_busy=1.
  - A MAR load during M_REQ does not change mem_addr.
  - mem_ack while in M_IDLE is ignored.
- The two FSMs run independently; an ALU operation and a memory access may overlap.

Test Plan:
- Reset and bus: clear=1, then one-hot select TB with tb_data=0xA5A5A5A5 and load Y → Y=0xA5A5A5A5 next cycle. Assert TB and PC selects together → bus=0, no load occurs, bus_conflict=1 and stays 1 until clear.
- RF and R0: write 0x12 to R0 and 0x34 to R5, then read both → R0=0, R5=0x34. With PC=0xFFFFFFFF, pc_inc=1 → PC=0. pc_inc together with a bus load of 7 → PC=7.
- ALU handshake: Y=6, bus=7, alu_start, external model drives alu_done after 3 cycles with result 42 → alu_req is high for exactly 3 cycles, Z=42, alu_busy falls. A second alu_start while busy → no effect.
- Memory read: MAR=0x100, mem_read, model acks after 2 wait cycles with 0xDEADBEEF → mem_addr=0x100, MDR=0xDEADBEEF. A MAR load and an MDR bus load mid-request → mem_addr and MDR are unchanged by them.
- Memory timeout and write: model never acks → after MEM_TIMEOUT cycles mem_req=0, mem_err=1, MDR unchanged. Then a write of MDR=0x55 with zero-wait ack → mem_we=1 and mem_wdata=0x55 for exactly one request cycle.
- Reset mid-operation: assert clear during M_REQ and during A_WAIT → mem_req and alu_req are low next cycle, both FSMs are IDLE, and every register is 0.
